mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous RAM between two requesters:
  - the fetch stage (instruction reads);
  - the memory stage (LDR/STR data accesses).
- Issues per-requester grants and routes read data back one cycle later.
- Produces per-stage stall signals for the pipeline controller.
- Data accesses win contention by default. A streak counter guarantees fetch forward progress.
- A branch-flush input discards an in-flight fetch read.

Parameters:
ADDR_W, 12, RAM word-address width
MAX_STREAK, 3, consecutive contended data grants allowed before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch read request, held until granted
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  32  fetch read data
if_flush  in  1  branch taken; drop any fetch read in flight
dm_req  in  1  data request, held until granted
dm_we  in  1  1 = STR (write), 0 = LDR (read)
dm_addr  in  ADDR_W  data word address
dm_wdata  in  32  store data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  load data valid
dm_rdata  out  32  load data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after a read access
stall_if  out  1  if_req & ~if_gnt
stall_mem  out  1  dm_req & ~dm_gnt

Behaviour:
- Grant decision is combinational from the current-cycle requests and the registered streak state:
  - only if_req: grant fetch;
  - only dm_req: grant data;
  - both, streak < MAX_STREAK: grant data;
  - both, streak == MAX_STREAK: grant fetch;
  - neither: no grant, ram_en = 0.
- At most one grant per cycle. if_gnt and dm_gnt are never both high.
- RAM drive:
  - ram_en equals the OR of the grants.
  - ram_addr, ram_we and ram_wdata are muxed from the granted requester.
  - Fetch grants always drive ram_we = 0. Data grants drive ram_we = dm_we.
  - With no grant: ram_addr = 0, ram_we = 0, ram_wdata = 0.
- Read return:
  - Registered owner state, enum NONE/IF/DM, captures which requester got a read grant.
  - Writes set owner to NONE.
  - In the next cycle, owner selects which rvalid asserts. Both rdata outputs are wired to ram_rdata.
  - Read latency is exactly 1 cycle after the grant.
  - Back-to-back grants every cycle are allowed, so throughput is 1 access per cycle.
- Writes produce no rvalid. The grant cycle is the completion.
- Flush:
  - if_flush high in a cycle where owner == IF forces if_rvalid low.
  - if_flush high in the same cycle as if_gnt clears the next-cycle owner to NONE.
  - The RAM read still occurs but is discarded.
  - if_flush never affects data accesses.
- Streak counter, 4 bits:
  - increments (saturating at MAX_STREAK) on cycles with dm_gnt & if_req;
  - clears to 0 on if_gnt, or on any cycle with if_req low;
  - otherwise holds.
- Reset values while rst is high (asynchronous):
  - owner = NONE, streak = 0;
  - if_rvalid = 0, dm_rvalid = 0.
  - Grants, RAM drive and stalls follow the combinational rules.
- Reset asserted mid-read: the pending rvalid is lost and never emitted.
- A requester that lowers req without a grant aborts cleanly. No state is retained.

Decomposition:
- Shared package (mem_arb_pkg):
  - owner_t enum {OWN_NONE, OWN_IF, OWN_DM};
  - STREAK_W = 4 constant.
- One natural sub-module, arb_streak_counter: the saturating streak counter plus the force_if output compare.
- Mux and owner logic stay in the top module.

Test Plan:
- Fetch only, addresses 0x000,0x001,0x002 back-to-back, RAM preloaded with 0xE000_0000+addr:
  - if_gnt on 3 consecutive cycles;
  - if_rvalid on each following cycle with matching data;
  - stall_if = 0 throughout.
- Simultaneous if_req @0x010 and dm_req LDR @0x100:
  - dm_gnt first, stall_if = 1;
  - dm_rvalid next cycle;
  - if_gnt the cycle after the data request drops.
- MAX_STREAK=3, if_req and dm_req held high for 6 cycles:
  - grant pattern DM,DM,DM,IF,DM,DM;
  - streak returns to 0 after the IF grant.
- STR 0xDEADBEEF @0x020 then LDR @0x020:
  - ram_we = 1 only on the STR grant cycle, no rvalid for the store;
  - LDR returns 0xDEADBEEF one cycle after its grant.
- Fetch granted @0x030 with if_flush the same cycle:
  - no if_rvalid next cycle;
  - a fetch granted the following cycle returns normally.
- Assert rst in the cycle after a data read grant:
  - dm_rvalid = 0 immediately (asynchronous);
  - owner = NONE, streak = 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The owner encoding records who receives the read data returned in the next cycle.
package mem_arb_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Counts consecutive data grants that were won while fetch was waiting.
// Asserts force_if once the limit is reached, so fetch cannot be starved.
module arb_streak_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                if_gnt,
  input  logic                dm_gnt,
  output logic [STREAK_W-1:0] streak,
  output logic                force_if
);

  localparam logic [STREAK_W-1:0] MAX_VAL = STREAK_W'(MAX_STREAK);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (dm_gnt && (streak != MAX_VAL)) begin
      streak <= streak + 1'b1;
    end
  end

  assign force_if = (streak == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and the data stage.
// Data wins contention unless the streak limit forces a fetch grant; reads return one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              if_flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  logic [STREAK_W-1:0] streak;
  logic                force_if;
  owner_t              owner;
  owner_t              owner_nxt;

  arb_streak_counter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_streak (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .streak  (streak),
    .force_if(force_if)
  );

  // Fetch wins only when alone or when data has held the port too long.
  assign if_gnt    = if_req && (!dm_req || force_if);
  assign dm_gnt    = dm_req && !if_gnt;
  assign stall_if  = if_req && !if_gnt;
  assign stall_mem = dm_req && !dm_gnt;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    owner_nxt = OWN_NONE;
    if (if_gnt) begin
      ram_en    = 1'b1;
      ram_addr  = if_addr;
      owner_nxt = if_flush ? OWN_NONE : OWN_IF;
    end else if (dm_gnt) begin
      ram_en    = 1'b1;
      ram_we    = dm_we;
      ram_addr  = dm_addr;
      ram_wdata = dm_wdata;
      owner_nxt = dm_we ? OWN_NONE : OWN_DM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  // A flush in the return cycle discards the fetch data; data returns are never affected.
  assign if_rvalid = (owner == OWN_IF) && !if_flush;
  assign dm_rvalid = (owner == OWN_DM);
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared
// against a transaction-level model with its own shadow memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int MAX_STREAK = 3;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush, dm_req, dm_we;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [31:0]       dm_wdata;
  logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0]       if_rdata, dm_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              stall_if, stall_mem;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_flush (if_flush),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM driven by the DUT.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          dm_run;
  bit          pend_if, pend_dm;
  logic [31:0] pend_data;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          g_if, g_dm;
  logic [5:0]  pattern;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive requests, compare combinational and returned outputs
  // against the model, then advance the model across the edge.
  task automatic step(input bit ireq, input logic [ADDR_W-1:0] iaddr, input bit iflush,
                      input bit dreq, input bit dwe, input logic [ADDR_W-1:0] daddr,
                      input logic [31:0] dwdata, output bit got_if, output bit got_dm);
    bit                exp_if, exp_dm;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
    if_req   = ireq;
    if_addr  = iaddr;
    if_flush = iflush;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
    #3;
    exp_if    = ireq && (!dreq || dm_run >= MAX_STREAK);
    exp_dm    = dreq && !exp_if;
    exp_addr  = exp_if ? iaddr : (exp_dm ? daddr : '0);
    exp_wdata = exp_dm ? dwdata : 32'h0;
    check("if_gnt",    32'(if_gnt),    32'(exp_if));
    check("dm_gnt",    32'(dm_gnt),    32'(exp_dm));
    check("stall_if",  32'(stall_if),  32'(ireq && !exp_if));
    check("stall_mem", 32'(stall_mem), 32'(dreq && !exp_dm));
    check("ram_en",    32'(ram_en),    32'(exp_if || exp_dm));
    check("ram_we",    32'(ram_we),    32'(exp_dm && dwe));
    check("ram_addr",  32'(ram_addr),  32'(exp_addr));
    if (!exp_if) check("ram_wdata", ram_wdata, exp_wdata);
    check("if_rvalid", 32'(if_rvalid), 32'(pend_if && !iflush));
    check("dm_rvalid", 32'(dm_rvalid), 32'(pend_dm));
    if (pend_if && !iflush) check("if_rdata", if_rdata, pend_data);
    if (pend_dm)            check("dm_rdata", dm_rdata, pend_data);
    @(posedge clk);
    pend_if   = exp_if && !iflush;
    pend_dm   = exp_dm && !dwe;
    pend_data = exp_if ? ref_mem[iaddr] : ref_mem[daddr];
    if (exp_dm && dwe) ref_mem[daddr] = dwdata;
    if (!ireq || exp_if) dm_run = 0;
    else if (exp_dm)     dm_run++;
    got_if = exp_if;
    got_dm = exp_dm;
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, '0, 32'h0, g_if, g_dm);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 32'hE000_0000 + i;
      ref_mem[i] = 32'hE000_0000 + i;
    end
    dm_run = 0; pend_if = 0; pend_dm = 0; pend_data = '0;
    #12;
    check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    check("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    check("rst_ram_en",    32'(ram_en),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back fetches.
    for (int a = 0; a < 3; a++) step(1, ADDR_W'(a), 0, 0, 0, '0, 32'h0, g_if, g_dm);
    check("fetch2_data", if_rdata, 32'hE000_0002);
    idle();

    // Contention: data first, fetch after data drops.
    step(1, 12'h010, 0, 1, 0, 12'h100, 32'h0, g_if, g_dm);
    check("contend_first_dm", 32'(g_dm), 32'h1);
    step(1, 12'h010, 0, 0, 0, '0, 32'h0, g_if, g_dm);
    check("contend_then_if", 32'(g_if), 32'h1);
    idle();

    // Streak limit under continuous contention: DM,DM,DM,IF,DM,DM.
    for (int c = 0; c < 6; c++) begin
      step(1, ADDR_W'(12'h200 + c), 0, 1, 0, ADDR_W'(12'h300 + c), 32'h0, g_if, g_dm);
      pattern[5-c] = g_dm;
    end
    check("streak_pattern", 32'(pattern), 32'b111011);
    idle();

    // Store then load of the same word.
    step(0, '0, 0, 1, 1, 12'h020, 32'hDEADBEEF, g_if, g_dm);
    step(0, '0, 0, 1, 0, 12'h020, 32'h0, g_if, g_dm);
    check("ldr_after_str", dm_rdata, 32'hDEADBEEF);
    idle();

    // Flushed fetch is dropped; the next fetch returns normally.
    step(1, 12'h030, 1, 0, 0, '0, 32'h0, g_if, g_dm);
    step(1, 12'h031, 0, 0, 0, '0, 32'h0, g_if, g_dm);
    idle();

    // Reset while a load return is pending.
    step(0, '0, 0, 1, 0, 12'h040, 32'h0, g_if, g_dm);
    check("pre_rst_dm_rvalid", 32'(dm_rvalid), 32'h1);
    if_req = 0; dm_req = 0;
    rst = 1'b1;
    #1;
    check("async_rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    pend_if = 0; pend_dm = 0; dm_run = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1, ADDR_W'(12'h050 + c), 0, 1, 0, ADDR_W'(12'h060 + c), 32'h0, g_if, g_dm);
      pattern[5-c] = g_dm;
    end
    check("post_rst_streak", 32'(pattern[5:2]), 32'b1110);
    idle();

    // Random traffic over a small address window so loads hit earlier stores.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 4) != 0, ADDR_W'($urandom % 64), ($urandom % 6) == 0,
           ($urandom % 4) != 0, ($urandom % 3) == 0, ADDR_W'($urandom % 64),
           $urandom, g_if, g_dm);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
